seven_seg_mux_driver: RTL

Time-multiplexed driver for a bank of `DIGITS` common-anode seven-segment digits, the multi-digit successor to the single-digit decimal decoder. It holds a packed BCD/hex value in a shadow register and scans one digit at a time at a programmable refresh rate. It adds hex mode, leading-zero blanking, decimal points, and tear-free value updates applied only at frame boundaries. It sits between the application's numeric output and the board's segment/anode pins.

---
 rtl/seven_seg_pkg.sv | 52 +++++
 rtl/seven_seg_decoder.sv | 16 +
 rtl/seven_seg_mux_driver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment encodings (active-low {a,b,c,d,e,f,g}) and the nibble decode function
// used by the seven-segment drivers.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0001100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_DASH  = 7'b1111110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Nibbles 10..15 render as a dash unless hex mode is selected.
  function automatic seg_t seg_decode(input logic [3:0] nibble, input logic hex_mode);
    seg_t seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_mode ? SEG_A : SEG_DASH;
      4'hB: seg = hex_mode ? SEG_B : SEG_DASH;
      4'hC: seg = hex_mode ? SEG_C : SEG_DASH;
      4'hD: seg = hex_mode ? SEG_D : SEG_DASH;
      4'hE: seg = hex_mode ? SEG_E : SEG_DASH;
      4'hF: seg = hex_mode ? SEG_F : SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational nibble-to-segment decoder with blanking; also usable standalone for a
// single-digit display.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = i_blank ? SEG_BLANK : seg_decode(i_nibble, i_hex_mode);
  end

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed common-anode driver: scans DIGITS digits from a shadow register that
// only takes new values at frame boundaries, so a frame never mixes old and new content.
module seven_seg_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            display_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     anode,
  output logic                  pending
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

  logic [PRE_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_pend_num, r_shd_num;
  logic [DIGITS-1:0]   r_pend_dp, r_shd_dp;
  logic                r_pend_hex, r_pend_blz, r_shd_hex, r_shd_blz, r_pending;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_anode;

  logic                w_tick, w_frame_end, w_last_idx;
  logic                w_allz, w_lz_sel, w_dp_sel, w_blank;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_onehot;
  logic [6:0]          w_seg;

  assign w_tick      = (r_pre == PRE_W'(REFRESH_DIV - 1));
  assign w_last_idx  = (r_idx == IDX_W'(DIGITS - 1));
  assign w_frame_end = w_tick && w_last_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) begin
        r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // A load coinciding with the frame end bypasses the pending register entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_num <= '0;
      r_pend_dp  <= '0;
      r_pend_hex <= 1'b0;
      r_pend_blz <= 1'b0;
      r_pending  <= 1'b0;
      r_shd_num  <= '0;
      r_shd_dp   <= '0;
      r_shd_hex  <= 1'b0;
      r_shd_blz  <= 1'b0;
    end else begin
      if (load) begin
        r_pend_num <= number;
        r_pend_dp  <= dp_in;
        r_pend_hex <= hex_mode;
        r_pend_blz <= blank_lz;
      end
      if (w_frame_end) begin
        r_pending <= 1'b0;
        if (load) begin
          r_shd_num <= number;
          r_shd_dp  <= dp_in;
          r_shd_hex <= hex_mode;
          r_shd_blz <= blank_lz;
        end else if (r_pending) begin
          r_shd_num <= r_pend_num;
          r_shd_dp  <= r_pend_dp;
          r_shd_hex <= r_pend_hex;
          r_shd_blz <= r_pend_blz;
        end
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Walk from the most significant digit down, tracking whether all nibbles so far are zero.
  always_comb begin
    w_allz   = 1'b1;
    w_lz_sel = 1'b0;
    w_dp_sel = 1'b0;
    w_nib    = 4'h0;
    w_onehot = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_allz = w_allz && (r_shd_num[4*k +: 4] == 4'h0);
      if (r_idx == IDX_W'(k)) begin
        w_onehot[k] = 1'b1;
        w_nib       = r_shd_num[4*k +: 4];
        w_dp_sel    = r_shd_dp[k];
        w_lz_sel    = w_allz && (k != 0);
      end
    end
  end

  assign w_blank = r_shd_blz && w_lz_sel;

  seven_seg_decoder u_decoder (
    .i_nibble   (w_nib),
    .i_hex_mode (r_shd_hex),
    .i_blank    (w_blank),
    .o_seg      (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
      r_anode <= '1;
    end else begin
      r_seg   <= w_seg;
      r_dp    <= ~w_dp_sel;
      r_anode <= ~w_onehot;
    end
  end

  assign display_out = r_seg;
  assign dp_out      = r_dp;
  assign anode       = r_anode;
  assign pending     = r_pending;

endmodule
